counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
Parametrised bank of CHANNELS synchronous modulo counters. It replaces the fixed three-output flip-flop counter/divider. Each channel has run-time modulus, direction, enable and parallel load. Channels can be cascaded synchronously, so channel i steps on channel i-1's wrap, giving multi-stage dividers with no ripple clocks. A shared prescaler sets the step rate, and each channel has a registered terminal-count pulse and a divided square-wave output for the lab display and timing logic.

Parameters:
WIDTH, 8, bits per channel counter
CHANNELS, 3, number of counter channels (>=1)
PRESCALE, 1, sysclk cycles per step tick (>=1; 1 = every cycle)

Ports:
sysclk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
en  in  CHANNELS  per-channel count enable
up  in  CHANNELS  direction, 1 = up, 0 = down
casc  in  CHANNELS  cascade select; bit 0 ignored
load  in  CHANNELS  synchronous parallel load strobe
load_val  in  CHANNELS*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
mod_val  in  CHANNELS*WIDTH  terminal value per channel (count range 0..mod_val)
count  out  CHANNELS*WIDTH  registered counter values
tc  out  CHANNELS  registered one-cycle wrap pulse
q  out  CHANNELS  registered divider output, toggles on every wrap

Behaviour:
- Clocking and reset: one clock domain. rstn low asynchronously forces count=0, tc=0, q=0 and prescaler=0 with no clock required. Outputs hold those values while rstn is low. The first step can occur on the first rising edge after rstn is released.
- Prescaler: 0..PRESCALE-1, wraps to 0. tick = (prescaler == PRESCALE-1). With PRESCALE=1, tick is always 1. The prescaler free-runs and is not affected by en or load.
- Carry-in: carry_in[0] = tick. For i>0, carry_in[i] = casc[i] ? wrap[i-1] : tick.
- Step: step[i] = en[i] & carry_in[i] & ~load[i].
- Wrap condition (combinational, current cycle):
  - up: step & (count >= mod_val)
  - down: step & (count == 0)
- Next count, in priority order:
  1. load[i]: count <= load_val. Ignores en and tick; wrap[i]=0.
  2. step & up: count >= mod_val -> 0; else count+1.
  3. step & down: count == 0 -> mod_val; count > mod_val -> mod_val with no wrap; else count-1.
  4. Otherwise hold.
- Out-of-range count after a mod_val change: handled by the rules above. Up wraps to 0 with tc. Down snaps to mod_val without tc. No state beyond 0..2^WIDTH-1 is reachable.
- mod_val = 0: up and down both wrap on every step; count stays 0.
- Arithmetic: unsigned, WIDTH bits. mod_val = all-ones gives a full 2^WIDTH range. No overflow is possible because of the rules above.
- tc[i] <= wrap[i], so tc is high exactly one cycle, in the cycle after the wrapping edge.
- q[i] toggles on the edge where wrap[i]=1. Divide ratio = 2*(mod_val+1) steps per q period.
- Cascade timing:
  - Carry propagates combinationally through the chain in one cycle, so all cascaded channels update on the same edge.
  - A loading channel generates no carry, even if its old value sits at the terminal value.
  - A disabled channel passes no carry.
- Simultaneous load on channel i while channel i-1 wraps: the load wins and the carry is dropped.
- Reset mid-operation: immediate clear. The prescaler phase restarts at 0.

Test Plan:
- Setup for scenarios 1–5: WIDTH=4, CHANNELS=3, PRESCALE=1.
1. Async reset: en=3'b001, up=1, mod_val[0]=15; run 5 cycles (count0=5). Drop rstn between edges -> count=0, tc=0, q=0 before the next edge. Release -> count0 = 1, 2, …
2. Up wrap: en0=1, up0=1, mod0=9 -> count0 = 0..9, 0; tc0=1 for exactly the one cycle after 9->0; q0 toggles 0->1 at that edge and 1->0 after the next wrap (20 cycles/period).
3. Down with load: mod0=5; pulse load0 with load_val0=2, then up0=0 -> count0 = 2, 1, 0, 5, 4; tc0 pulses after 0->5. Then set mod0=3 while count0=5 -> next count0=3 and no tc.
4. Cascade: mod=1 on all channels, en=3'b111, up=3'b111, casc=3'b110 -> count0 toggles every cycle; count1 steps every 2 cycles; count2 every 4; q0/q1/q2 periods 4/8/16 cycles. Ch1 and ch2 change on the same edge as ch0's wrap.
5. Priority: during the cycle ch0 wraps, assert load1 with load_val1=7 and en1=0 -> count1=7, tc1 stays 0. Next cycle, en2=0 and ch1 wraps -> count2 holds.
6. PRESCALE=4, en0=1, up0=1, mod0=15 -> count0 increments on every 4th edge after reset release (cycles 4, 8, 12, …); load remains effective on any cycle.

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: a bank of synchronous modulo counters that share one step prescaler.
// Each channel can step on the shared tick or on the wrap of the channel below it.
// Each channel also has a registered terminal-count pulse and a divide-by-2 output.
module counter_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                         sysclk,
    input  logic                         rstn,
    input  logic [CHANNELS-1:0]          en,
    input  logic [CHANNELS-1:0]          up,
    input  logic [CHANNELS-1:0]          casc,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_val,
    input  logic [CHANNELS*WIDTH-1:0]    mod_val,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          tc,
    output logic [CHANNELS-1:0]          q
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]           r_ps;
    logic [CHANNELS*WIDTH-1:0] r_count;
    logic [CHANNELS-1:0]       r_tc;
    logic [CHANNELS-1:0]       r_q;

    logic                      w_tick;
    logic [PS_W-1:0]           w_ps_next;
    logic [CHANNELS-1:0]       w_wrap;
    logic [CHANNELS*WIDTH-1:0] w_next;
    logic                      w_chain;
    logic                      w_carry;
    logic                      w_step;
    logic [WIDTH-1:0]          w_cur;
    logic [WIDTH-1:0]          w_mod;

    // Prescaler decode: tick on the last phase. A one-phase prescaler ticks every cycle.
    always_comb begin
        w_tick    = (r_ps == PS_W'(PRESCALE - 1));
        w_ps_next = w_tick ? '0 : r_ps + PS_W'(1);
    end

    // Per-channel next count and wrap.
    // The carry chain runs through the channels in order, so a cascade settles in one cycle.
    always_comb begin
        w_wrap  = '0;
        w_next  = r_count;
        w_chain = 1'b0;
        w_carry = 1'b0;
        w_step  = 1'b0;
        w_cur   = '0;
        w_mod   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cur   = r_count[i*WIDTH +: WIDTH];
            w_mod   = mod_val[i*WIDTH +: WIDTH];
            w_carry = ((i > 0) && casc[i]) ? w_chain : w_tick;
            w_step  = en[i] & w_carry & ~load[i];
            if (load[i]) begin
                w_next[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
            end else if (w_step && up[i]) begin
                if (w_cur >= w_mod) begin
                    w_next[i*WIDTH +: WIDTH] = '0;
                    w_wrap[i]                = 1'b1;
                end else begin
                    w_next[i*WIDTH +: WIDTH] = w_cur + WIDTH'(1);
                end
            end else if (w_step) begin
                if (w_cur == '0) begin
                    w_next[i*WIDTH +: WIDTH] = w_mod;
                    w_wrap[i]                = 1'b1;
                end else if (w_cur > w_mod) begin
                    // The count is out of range after a modulus change: snap back silently.
                    w_next[i*WIDTH +: WIDTH] = w_mod;
                end else begin
                    w_next[i*WIDTH +: WIDTH] = w_cur - WIDTH'(1);
                end
            end
            w_chain = w_wrap[i];
        end
    end

    // State registers. Reset clears them at once; a terminal-count pulse follows each wrap by one cycle.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_ps    <= '0;
            r_count <= '0;
            r_tc    <= '0;
            r_q     <= '0;
        end else begin
            r_ps    <= w_ps_next;
            r_count <= w_next;
            r_tc    <= w_wrap;
            r_q     <= r_q ^ w_wrap;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign q     = r_q;

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank. It drives two instances with the same inputs: one with a prescale of 1, one with a prescale of 4.
// Both are compared each cycle against a behavioural model. Fixed literal values pin the model.
module tb_counter_bank;

    localparam int W  = 4;
    localparam int CH = 3;

    logic              sysclk;
    logic              rstn;
    logic [CH-1:0]     en, up, casc, load;
    logic [CH*W-1:0]   load_val, mod_val;
    logic [CH*W-1:0]   count_a, count_b;
    logic [CH-1:0]     tc_a, tc_b, q_a, q_b;

    int checks   = 0;
    int failures = 0;

    int m_cnt [2][CH];
    bit m_tc  [2][CH];
    bit m_q   [2][CH];
    int m_ps  [2];

    counter_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) u_dut_a (
        .sysclk(sysclk), .rstn(rstn), .en(en), .up(up), .casc(casc), .load(load),
        .load_val(load_val), .mod_val(mod_val), .count(count_a), .tc(tc_a), .q(q_a)
    );

    counter_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) u_dut_b (
        .sysclk(sysclk), .rstn(rstn), .en(en), .up(up), .casc(casc), .load(load),
        .load_val(load_val), .mod_val(mod_val), .count(count_b), .tc(tc_b), .q(q_b)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Safety net in case the run stops advancing.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ps[d] = 0;
            for (int i = 0; i < CH; i++) begin
                m_cnt[d][i] = 0;
                m_tc[d][i]  = 0;
                m_q[d][i]   = 0;
            end
        end
    endtask

    // One rising edge of the model, using the inputs as they stand now.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit tick, chain, carry, step, wrap;
            int p, c, mv;
            p     = (d == 0) ? 1 : 4;
            tick  = (m_ps[d] == p - 1);
            m_ps[d] = tick ? 0 : m_ps[d] + 1;
            chain = 0;
            for (int i = 0; i < CH; i++) begin
                c     = m_cnt[d][i];
                mv    = int'(mod_val[i*W +: W]);
                carry = (i > 0 && casc[i]) ? chain : tick;
                step  = en[i] && carry && !load[i];
                wrap  = 0;
                if (load[i]) c = int'(load_val[i*W +: W]);
                else if (step && up[i]) begin
                    if (c >= mv) begin c = 0; wrap = 1; end
                    else c = c + 1;
                end else if (step) begin
                    if (c == 0) begin c = mv; wrap = 1; end
                    else if (c > mv) c = mv;
                    else c = c - 1;
                end
                m_cnt[d][i] = c;
                m_tc[d][i]  = wrap;
                if (wrap) m_q[d][i] = !m_q[d][i];
                chain = wrap;
            end
        end
    endtask

    // Compare every output of both instances with the model.
    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                int ac, at, aq;
                ac = (d == 0) ? int'(count_a[i*W +: W]) : int'(count_b[i*W +: W]);
                at = (d == 0) ? int'(tc_a[i]) : int'(tc_b[i]);
                aq = (d == 0) ? int'(q_a[i]) : int'(q_b[i]);
                check($sformatf("model_count d%0d ch%0d", d, i), ac, m_cnt[d][i]);
                check($sformatf("model_tc d%0d ch%0d", d, i), at, int'(m_tc[d][i]));
                check($sformatf("model_q d%0d ch%0d", d, i), aq, int'(m_q[d][i]));
            end
        end
    endtask

    // Advance one clock, then compare at the falling edge.
    task automatic cycle();
        @(posedge sysclk);
        if (rstn) model_edge();
        @(negedge sysclk);
        compare();
    endtask

    task automatic set_idle();
        en = '0; up = '0; casc = '0; load = '0; load_val = '0; mod_val = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) cycle();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        set_idle();
        model_reset();
        @(negedge sysclk);
        compare();
        check("reset_count_a", int'(count_a), 0);
        check("reset_q_b", int'(q_b), 0);
        do_reset();

        // Asynchronous reset in the middle of counting.
        en = 3'b001; up = 3'b111; mod_val = 12'hFFF;
        repeat (5) cycle();
        check("s1_count0_5", int'(count_a[3:0]), 5);
        rstn = 1'b0;
        #1;
        check("s1_async_count_a", int'(count_a), 0);
        check("s1_async_count_b", int'(count_b), 0);
        check("s1_async_tc_q", int'({tc_a, q_a}), 0);
        model_reset();
        cycle();
        rstn = 1'b1;
        cycle();
        check("s1_release_1", int'(count_a[3:0]), 1);
        cycle();
        check("s1_release_2", int'(count_a[3:0]), 2);

        // Count up and wrap at modulus 9.
        do_reset();
        en = 3'b001; up = 3'b001; mod_val = 12'h009;
        repeat (9) cycle();
        check("s2_count_9", int'(count_a[3:0]), 9);
        check("s2_tc_before", int'(tc_a[0]), 0);
        cycle();
        check("s2_wrap_count", int'(count_a[3:0]), 0);
        check("s2_wrap_tc", int'(tc_a[0]), 1);
        check("s2_wrap_q", int'(q_a[0]), 1);
        cycle();
        check("s2_tc_one_cycle", int'(tc_a[0]), 0);
        repeat (9) cycle();
        check("s2_q_back", int'(q_a[0]), 0);

        // Load, then count down; change the modulus while the count is out of range.
        do_reset();
        en = 3'b001; up = 3'b001; mod_val = 12'h005; load = 3'b001; load_val = 12'h002;
        cycle();
        check("s3_load", int'(count_a[3:0]), 2);
        load = '0; up = 3'b000;
        cycle(); check("s3_down_1", int'(count_a[3:0]), 1);
        cycle(); check("s3_down_0", int'(count_a[3:0]), 0);
        cycle(); check("s3_wrap_5", int'(count_a[3:0]), 5);
        check("s3_wrap_tc", int'(tc_a[0]), 1);
        mod_val = 12'h003;
        cycle(); check("s3_snap_3", int'(count_a[3:0]), 3);
        check("s3_snap_no_tc", int'(tc_a[0]), 0);

        // Three-stage cascade with modulus 1.
        do_reset();
        en = 3'b111; up = 3'b111; casc = 3'b110; mod_val = 12'h111;
        repeat (4) cycle();
        check("s4_counts", int'(count_a), 'h100);
        check("s4_tc", int'(tc_a), 3);
        repeat (12) cycle();
        check("s4_q_after16", int'(q_a), 3'b000);

        // A load beats a cascade carry; a disabled channel passes no carry.
        do_reset();
        en = 3'b001; up = 3'b111; casc = 3'b110; mod_val = 12'h111;
        cycle();
        load = 3'b010; load_val = 12'h070;
        cycle();
        check("s5_load_wins", int'(count_a[7:4]), 7);
        check("s5_no_tc1", int'(tc_a[1]), 0);
        load = '0; en = 3'b011;
        cycle();
        cycle();
        check("s5_ch1_wrap", int'(count_a[7:4]), 0);
        check("s5_tc1", int'(tc_a[1]), 1);
        check("s5_ch2_hold", int'(count_a[11:8]), 0);

        // Prescale of 4: a step on every 4th edge, and a load on any cycle.
        do_reset();
        en = 3'b001; up = 3'b001; mod_val = 12'h00F;
        repeat (3) cycle();
        check("s6_b_0", int'(count_b[3:0]), 0);
        cycle();
        check("s6_b_1", int'(count_b[3:0]), 1);
        repeat (4) cycle();
        check("s6_b_2", int'(count_b[3:0]), 2);
        load = 3'b001; load_val = 12'h009;
        cycle();
        check("s6_b_load", int'(count_b[3:0]), 9);
        load = '0;

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rstn = 1'b0;
                model_reset();
            end else begin
                rstn = 1'b1;
            end
            for (int i = 0; i < CH; i++) begin
                logic [W-1:0] mv;
                en[i]   = ($urandom_range(0, 3) != 0);
                load[i] = ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 3))
                    0:       mv = W'($urandom);
                    1:       mv = '1;
                    default: mv = W'($urandom_range(0, 3));
                endcase
                if ($urandom_range(0, 7) == 0) mod_val[i*W +: W] = mv;
            end
            if ($urandom_range(0, 15) == 0) up = CH'($urandom);
            if ($urandom_range(0, 31) == 0) casc = CH'($urandom);
            load_val = (CH*W)'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
